// File: rtl/accel_mem_host.sv
// accel_mem_host: operand/result memory with accelerator read/write-back port,
// host preload/readback port and the start/arm/run/done job sequencer.
module accel_mem_host #(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 4,
  parameter int ARM_CYCLES = 2,
  parameter int TIMEOUT    = 255,
  parameter int RES_ADDR   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr_en,
  input  logic              host_rd_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              host_start,
  output logic              host_busy,
  output logic              host_done,
  output logic              host_err,
  output logic [DATA_W-1:0] result,
  output logic              comp_enb,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_read_enb,
  input  logic              mem_write_enb,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic [DATA_W-1:0] res_data,
  input  logic              busyb,
  input  logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [7:0] ARM_LAST = 8'(ARM_CYCLES - 1);
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam logic [ADDR_W-1:0] RES_A = ADDR_W'(RES_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              comp_enb_q, comp_enb_d;
  logic [7:0]        arm_cnt_q, arm_cnt_d;
  logic [7:0]        tmo_cnt_q, tmo_cnt_d;
  logic [7:0]        tmo_next;
  logic              host_wr_ok;
  logic              acc_wr_ok;
  logic              unused_inputs;

  assign unused_inputs = ^{mem_read_enb, busyb};

  assign host_wr_ok = host_wr_en && (state_q == IDLE);
  assign acc_wr_ok  = !mem_write_enb && (state_q == RUN);
  assign tmo_next   = tmo_cnt_q + 8'd1;

  assign mem_data   = mem_q[mem_addr];
  assign host_rdata = host_rdata_q;
  assign result     = result_q;
  assign host_busy  = busy_q;
  assign host_done  = done_q;
  assign host_err   = err_q;
  assign comp_enb   = comp_enb_q;

  always_comb begin
    state_d      = state_q;
    arm_cnt_d    = arm_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    result_d     = result_q;
    done_d       = done_q;
    err_d        = err_q;
    host_rdata_d = host_rd_en ? mem_q[host_addr] : host_rdata_q;

    if (state_q != IDLE && (host_wr_en || host_start)) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (host_start) begin
          state_d   = ARM;
          arm_cnt_d = 8'd0;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end
      end
      ARM: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = RUN;
          tmo_cnt_d = 8'd0;
        end else begin
          arm_cnt_d = arm_cnt_q + 8'd1;
        end
      end
      RUN: begin
        if (done) begin
          state_d = IDLE;
          done_d  = 1'b1;
          // Forward a write-back landing on the completion edge itself.
          if (acc_wr_ok && res_addr == RES_A) begin
            result_d = res_data;
          end else begin
            result_d = mem_q[RES_A];
          end
        end else begin
          tmo_cnt_d = tmo_next;
          if (tmo_next == TMO) begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    comp_enb_d = (state_d != RUN);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      arm_cnt_q    <= 8'd0;
      tmo_cnt_q    <= 8'd0;
      host_rdata_q <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      comp_enb_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      arm_cnt_q    <= arm_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      host_rdata_q <= host_rdata_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      comp_enb_q   <= comp_enb_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (host_wr_ok) begin
      mem_q[host_addr] <= host_wdata;
    end else if (acc_wr_ok) begin
      mem_q[res_addr] <= res_data;
    end
  end

endmodule
